// File: rtl/eth_rx_frame_fifo_pkg.sv
// eth_rx_frame_fifo_pkg: shared defaults and write-FSM state encoding for the rx frame FIFO
package eth_rx_frame_fifo_pkg;
  localparam int ADDR_W_DEF = 11;
  localparam int CNT_W_DEF = 32;
  typedef enum logic [1:0] {WR_IDLE, WR_FRAME, WR_DROP} wr_state_e;
endpackage

// File: rtl/eth_rx_fifo_ram.sv
// eth_rx_fifo_ram: simple dual-port {tlast,tdata} store with enabled registered read
module eth_rx_fifo_ram #(
  parameter int ADDR_W = 11
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [8:0]        wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [8:0]        rdata_o
);
  logic [8:0] mem [2**ADDR_W];
  always_ff @(posedge clk) begin
    if (we_i) mem[waddr_i] <= wdata_i;
    if (re_i) rdata_o <= mem[raddr_i];
  end
endmodule

// File: rtl/eth_rx_frame_fifo.sv
// eth_rx_frame_fifo: store-and-forward rx FIFO that forwards only good, complete frames
module eth_rx_frame_fifo
  import eth_rx_frame_fifo_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       s_axis_tdata,
  input  logic             s_axis_tvalid,
  input  logic             s_axis_tlast,
  input  logic             s_axis_tuser,
  output logic [7:0]       m_axis_tdata,
  output logic             m_axis_tvalid,
  output logic             m_axis_tlast,
  input  logic             m_axis_tready,
  output logic [CNT_W-1:0] cnt_ok,
  output logic [CNT_W-1:0] cnt_bad,
  output logic [CNT_W-1:0] cnt_ovf,
  output logic             frm_pending
);
  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};
  wr_state_e state_q, state_d;
  logic [ADDR_W:0] wr_ptr_q, wr_ptr_d, wr_cmt_q, wr_cmt_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_ok_q, cnt_bad_q, cnt_ovf_q;
  logic inc_ok, inc_bad, inc_ovf, we, re, full, avail, vld_q, vld_d, pend_q;
  logic [8:0] rdata;
  assign full = (wr_ptr_q - rd_ptr_q) == DEPTH;
  always_comb begin
    state_d = state_q;
    wr_ptr_d = wr_ptr_q;
    wr_cmt_d = wr_cmt_q;
    we = 1'b0;
    inc_ok = 1'b0;
    inc_bad = 1'b0;
    inc_ovf = 1'b0;
    if (s_axis_tvalid) begin
      if (state_q == WR_DROP) begin
        inc_ovf = s_axis_tlast;
        state_d = s_axis_tlast ? WR_IDLE : WR_DROP;
      end else if (s_axis_tlast && s_axis_tuser) begin
        wr_ptr_d = wr_cmt_q;
        inc_bad = 1'b1;
        state_d = WR_IDLE;
      end else if (full) begin
        wr_ptr_d = wr_cmt_q;
        inc_ovf = s_axis_tlast;
        state_d = s_axis_tlast ? WR_IDLE : WR_DROP;
      end else begin
        we = 1'b1;
        wr_ptr_d = wr_ptr_q + 1'b1;
        wr_cmt_d = s_axis_tlast ? wr_ptr_q + 1'b1 : wr_cmt_q;
        inc_ok = s_axis_tlast;
        state_d = s_axis_tlast ? WR_IDLE : WR_FRAME;
      end
    end
  end
  // The RAM read register doubles as the output stage: it only reloads when empty or consumed.
  assign avail = rd_ptr_q != wr_cmt_q;
  assign re = avail && (!vld_q || m_axis_tready);
  assign rd_ptr_d = re ? rd_ptr_q + 1'b1 : rd_ptr_q;
  assign vld_d = re || (vld_q && !m_axis_tready);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= WR_IDLE;
      wr_ptr_q <= '0;
      wr_cmt_q <= '0;
      rd_ptr_q <= '0;
      vld_q <= 1'b0;
      pend_q <= 1'b0;
      cnt_ok_q <= '0;
      cnt_bad_q <= '0;
      cnt_ovf_q <= '0;
    end else begin
      state_q <= state_d;
      wr_ptr_q <= wr_ptr_d;
      wr_cmt_q <= wr_cmt_d;
      rd_ptr_q <= rd_ptr_d;
      vld_q <= vld_d;
      pend_q <= avail || vld_q;
      cnt_ok_q <= cnt_ok_q + CNT_W'(inc_ok);
      cnt_bad_q <= cnt_bad_q + CNT_W'(inc_bad);
      cnt_ovf_q <= cnt_ovf_q + CNT_W'(inc_ovf);
    end
  end
  eth_rx_fifo_ram #(.ADDR_W(ADDR_W)) u_ram (
    .clk     (clk),
    .we_i    (we),
    .waddr_i (wr_ptr_q[ADDR_W-1:0]),
    .wdata_i ({s_axis_tlast, s_axis_tdata}),
    .re_i    (re),
    .raddr_i (rd_ptr_q[ADDR_W-1:0]),
    .rdata_o (rdata)
  );
  assign m_axis_tvalid = vld_q;
  assign m_axis_tdata = vld_q ? rdata[7:0] : 8'h00;
  assign m_axis_tlast = vld_q && rdata[8];
  assign frm_pending = pend_q;
  assign cnt_ok = cnt_ok_q;
  assign cnt_bad = cnt_bad_q;
  assign cnt_ovf = cnt_ovf_q;
endmodule
